// File: rtl/axi_arb_pkg.sv
// Shared types and constants for the 2:1 AXI4-lite arbiter.
//   arb_state_t : arbiter FSM state (idle / write in flight / read in flight)
//   ARB_M0/M1   : master identifiers used for grant_id and last_id
package axi_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_WRITE = 2'd1,
    ARB_READ  = 2'd2
  } arb_state_t;

  localparam logic ARB_M0 = 1'b0;
  localparam logic ARB_M1 = 1'b1;

endpackage

// File: rtl/axi_arb_pick.sv
// Combinational two-requester picker.
// Policy selected by macro AXI_ARB_ROUND_ROBIN_EN:
//   defined     : on a tie the master that was not served last wins
//   not defined : fixed priority, m0 wins every tie
// Ports:
//   req_i[1:0]  in   request per master
//   last_id_i   in   master that completed the previous transaction
//   pick_o      out  selected master (ARB_M0 when nothing requests)
//   any_o       out  at least one request pending
module axi_arb_pick
  import axi_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_id_i,
  output logic       pick_o,
  output logic       any_o
);

  assign any_o = |req_i;

`ifdef AXI_ARB_ROUND_ROBIN_EN
  always_comb begin
    pick_o = ARB_M0;
    if (&req_i) begin
      pick_o = ~last_id_i;
    end else if (req_i[1]) begin
      pick_o = ARB_M1;
    end
  end
`else
  logic unused_last_id;
  assign unused_last_id = last_id_i;

  always_comb begin
    pick_o = ARB_M0;
    if (!req_i[0] && req_i[1]) begin
      pick_o = ARB_M1;
    end
  end
`endif

endmodule

// File: rtl/axi_lite_arbiter_2to1.sv
// 2:1 AXI4-lite arbiter: two masters (m0 = CPU, m1 = loader/DMA) share one slave.
// One transaction in flight; the grant is held until that transaction's response handshake,
// then one idle cycle precedes the next grant. Writes win over reads from the same master.
// Tie policy: macro AXI_ARB_ROUND_ROBIN_EN (see axi_arb_pick); default is fixed m0 priority.
// Ports:
//   clk, resetn          clock, asynchronous active-low reset
//   m{0,1}_axi_*         master-side AXI4-lite (no bresp/rresp)
//   s_axi_*              slave-side AXI4-lite towards the memory
//   grant_id             master owning the slave (meaningful while busy)
//   busy                 a transaction is in flight
module axi_lite_arbiter_2to1
  import axi_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                clk,
  input  logic                resetn,
  // master 0
  input  logic                m0_axi_awvalid,
  output logic                m0_axi_awready,
  input  logic [ADDR_W-1:0]   m0_axi_awaddr,
  input  logic [2:0]          m0_axi_awprot,
  input  logic                m0_axi_wvalid,
  output logic                m0_axi_wready,
  input  logic [DATA_W-1:0]   m0_axi_wdata,
  input  logic [DATA_W/8-1:0] m0_axi_wstrb,
  output logic                m0_axi_bvalid,
  input  logic                m0_axi_bready,
  input  logic                m0_axi_arvalid,
  output logic                m0_axi_arready,
  input  logic [ADDR_W-1:0]   m0_axi_araddr,
  input  logic [2:0]          m0_axi_arprot,
  output logic                m0_axi_rvalid,
  input  logic                m0_axi_rready,
  output logic [DATA_W-1:0]   m0_axi_rdata,
  // master 1
  input  logic                m1_axi_awvalid,
  output logic                m1_axi_awready,
  input  logic [ADDR_W-1:0]   m1_axi_awaddr,
  input  logic [2:0]          m1_axi_awprot,
  input  logic                m1_axi_wvalid,
  output logic                m1_axi_wready,
  input  logic [DATA_W-1:0]   m1_axi_wdata,
  input  logic [DATA_W/8-1:0] m1_axi_wstrb,
  output logic                m1_axi_bvalid,
  input  logic                m1_axi_bready,
  input  logic                m1_axi_arvalid,
  output logic                m1_axi_arready,
  input  logic [ADDR_W-1:0]   m1_axi_araddr,
  input  logic [2:0]          m1_axi_arprot,
  output logic                m1_axi_rvalid,
  input  logic                m1_axi_rready,
  output logic [DATA_W-1:0]   m1_axi_rdata,
  // slave
  output logic                s_axi_awvalid,
  input  logic                s_axi_awready,
  output logic [ADDR_W-1:0]   s_axi_awaddr,
  output logic [2:0]          s_axi_awprot,
  output logic                s_axi_wvalid,
  input  logic                s_axi_wready,
  output logic [DATA_W-1:0]   s_axi_wdata,
  output logic [DATA_W/8-1:0] s_axi_wstrb,
  input  logic                s_axi_bvalid,
  output logic                s_axi_bready,
  output logic                s_axi_arvalid,
  input  logic                s_axi_arready,
  output logic [ADDR_W-1:0]   s_axi_araddr,
  output logic [2:0]          s_axi_arprot,
  input  logic                s_axi_rvalid,
  output logic                s_axi_rready,
  input  logic [DATA_W-1:0]   s_axi_rdata,
  // status
  output logic                grant_id,
  output logic                busy
);

  localparam int unsigned StrbW = DATA_W / 8;

  arb_state_t state_q, state_d;
  logic       grant_q, grant_d;
  logic       last_q, last_d;
  logic       aw_done_q, aw_done_d;
  logic       w_done_q, w_done_d;
  logic       ar_done_q, ar_done_d;

  logic [1:0] req_w, req_r, req;
  logic       pick, pick_any;

  assign req_w = {m1_axi_awvalid, m0_axi_awvalid};
  assign req_r = {m1_axi_arvalid, m0_axi_arvalid};
  assign req   = req_w | req_r;

  axi_arb_pick u_pick (
    .req_i     (req),
    .last_id_i (last_q),
    .pick_o    (pick),
    .any_o     (pick_any)
  );

  // Inputs of the currently granted master
  logic              g_awvalid, g_wvalid, g_bready, g_arvalid, g_rready;
  logic [ADDR_W-1:0] g_awaddr, g_araddr;
  logic [2:0]        g_awprot, g_arprot;
  logic [DATA_W-1:0] g_wdata;
  logic [StrbW-1:0]  g_wstrb;

  assign g_awvalid = grant_q ? m1_axi_awvalid : m0_axi_awvalid;
  assign g_awaddr  = grant_q ? m1_axi_awaddr  : m0_axi_awaddr;
  assign g_awprot  = grant_q ? m1_axi_awprot  : m0_axi_awprot;
  assign g_wvalid  = grant_q ? m1_axi_wvalid  : m0_axi_wvalid;
  assign g_wdata   = grant_q ? m1_axi_wdata   : m0_axi_wdata;
  assign g_wstrb   = grant_q ? m1_axi_wstrb   : m0_axi_wstrb;
  assign g_bready  = grant_q ? m1_axi_bready  : m0_axi_bready;
  assign g_arvalid = grant_q ? m1_axi_arvalid : m0_axi_arvalid;
  assign g_araddr  = grant_q ? m1_axi_araddr  : m0_axi_araddr;
  assign g_arprot  = grant_q ? m1_axi_arprot  : m0_axi_arprot;
  assign g_rready  = grant_q ? m1_axi_rready  : m0_axi_rready;

  // Outputs towards the granted master; all zero outside the matching state
  logic              g_awready, g_wready, g_bvalid, g_arready, g_rvalid;
  logic [DATA_W-1:0] g_rdata;

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    ar_done_d = ar_done_q;

    s_axi_awvalid = 1'b0;
    s_axi_awaddr  = '0;
    s_axi_awprot  = '0;
    s_axi_wvalid  = 1'b0;
    s_axi_wdata   = '0;
    s_axi_wstrb   = '0;
    s_axi_bready  = 1'b0;
    s_axi_arvalid = 1'b0;
    s_axi_araddr  = '0;
    s_axi_arprot  = '0;
    s_axi_rready  = 1'b0;

    g_awready = 1'b0;
    g_wready  = 1'b0;
    g_bvalid  = 1'b0;
    g_arready = 1'b0;
    g_rvalid  = 1'b0;
    g_rdata   = '0;

    unique case (state_q)
      ARB_IDLE: begin
        if (pick_any) begin
          grant_d   = pick;
          // Write first keeps a store ahead of a later load from the same master
          state_d   = req_w[pick] ? ARB_WRITE : ARB_READ;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          ar_done_d = 1'b0;
        end
      end

      ARB_WRITE: begin
        s_axi_awvalid = g_awvalid & ~aw_done_q;
        s_axi_awaddr  = g_awaddr;
        s_axi_awprot  = g_awprot;
        s_axi_wvalid  = g_wvalid & ~w_done_q;
        s_axi_wdata   = g_wdata;
        s_axi_wstrb   = g_wstrb;
        s_axi_bready  = g_bready;
        g_awready     = s_axi_awready & ~aw_done_q;
        g_wready      = s_axi_wready & ~w_done_q;
        g_bvalid      = s_axi_bvalid;
        if (g_awvalid && !aw_done_q && s_axi_awready) begin
          aw_done_d = 1'b1;
        end
        if (g_wvalid && !w_done_q && s_axi_wready) begin
          w_done_d = 1'b1;
        end
        if (s_axi_bvalid && g_bready) begin
          state_d = ARB_IDLE;
          last_d  = grant_q;
        end
      end

      ARB_READ: begin
        s_axi_arvalid = g_arvalid & ~ar_done_q;
        s_axi_araddr  = g_araddr;
        s_axi_arprot  = g_arprot;
        s_axi_rready  = g_rready;
        g_arready     = s_axi_arready & ~ar_done_q;
        g_rvalid      = s_axi_rvalid;
        g_rdata       = s_axi_rdata;
        if (g_arvalid && !ar_done_q && s_axi_arready) begin
          ar_done_d = 1'b1;
        end
        if (s_axi_rvalid && g_rready) begin
          state_d = ARB_IDLE;
          last_d  = grant_q;
        end
      end

      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ARB_IDLE;
      grant_q   <= ARB_M0;
      last_q    <= ARB_M1;  // m0 wins the first tie after reset
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      ar_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      ar_done_q <= ar_done_d;
    end
  end

  logic sel0, sel1;
  assign sel0 = (grant_q == ARB_M0);
  assign sel1 = (grant_q == ARB_M1);

  assign m0_axi_awready = g_awready & sel0;
  assign m0_axi_wready  = g_wready  & sel0;
  assign m0_axi_bvalid  = g_bvalid  & sel0;
  assign m0_axi_arready = g_arready & sel0;
  assign m0_axi_rvalid  = g_rvalid  & sel0;
  assign m0_axi_rdata   = sel0 ? g_rdata : '0;

  assign m1_axi_awready = g_awready & sel1;
  assign m1_axi_wready  = g_wready  & sel1;
  assign m1_axi_bvalid  = g_bvalid  & sel1;
  assign m1_axi_arready = g_arready & sel1;
  assign m1_axi_rvalid  = g_rvalid  & sel1;
  assign m1_axi_rdata   = sel1 ? g_rdata : '0;

  assign grant_id = grant_q;
  assign busy     = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_axi_lite_arbiter_2to1.sv
// Bench for axi_lite_arbiter_2to1: two master driver tasks, a behavioural memory slave,
// and a monitor that pops expected grants/read data/write responses from queues.
module tb_axi_lite_arbiter_2to1;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  // master-side signals, index = master id
  logic        m_awvalid [2], m_awready [2], m_wvalid [2], m_wready [2];
  logic        m_bvalid [2], m_bready [2], m_arvalid [2], m_arready [2];
  logic        m_rvalid [2], m_rready [2];
  logic [31:0] m_awaddr [2], m_araddr [2], m_wdata [2], m_rdata [2];
  logic [2:0]  m_awprot [2], m_arprot [2];
  logic [3:0]  m_wstrb [2];

  logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic        s_arvalid, s_arready, s_rvalid, s_rready;
  logic [31:0] s_awaddr, s_araddr, s_wdata, s_rdata;
  logic [2:0]  s_awprot, s_arprot;
  logic [3:0]  s_wstrb;
  logic        grant_id, busy;

  axi_lite_arbiter_2to1 #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .resetn(resetn),
    .m0_axi_awvalid(m_awvalid[0]), .m0_axi_awready(m_awready[0]), .m0_axi_awaddr(m_awaddr[0]),
    .m0_axi_awprot(m_awprot[0]), .m0_axi_wvalid(m_wvalid[0]), .m0_axi_wready(m_wready[0]),
    .m0_axi_wdata(m_wdata[0]), .m0_axi_wstrb(m_wstrb[0]), .m0_axi_bvalid(m_bvalid[0]),
    .m0_axi_bready(m_bready[0]), .m0_axi_arvalid(m_arvalid[0]), .m0_axi_arready(m_arready[0]),
    .m0_axi_araddr(m_araddr[0]), .m0_axi_arprot(m_arprot[0]), .m0_axi_rvalid(m_rvalid[0]),
    .m0_axi_rready(m_rready[0]), .m0_axi_rdata(m_rdata[0]),
    .m1_axi_awvalid(m_awvalid[1]), .m1_axi_awready(m_awready[1]), .m1_axi_awaddr(m_awaddr[1]),
    .m1_axi_awprot(m_awprot[1]), .m1_axi_wvalid(m_wvalid[1]), .m1_axi_wready(m_wready[1]),
    .m1_axi_wdata(m_wdata[1]), .m1_axi_wstrb(m_wstrb[1]), .m1_axi_bvalid(m_bvalid[1]),
    .m1_axi_bready(m_bready[1]), .m1_axi_arvalid(m_arvalid[1]), .m1_axi_arready(m_arready[1]),
    .m1_axi_araddr(m_araddr[1]), .m1_axi_arprot(m_arprot[1]), .m1_axi_rvalid(m_rvalid[1]),
    .m1_axi_rready(m_rready[1]), .m1_axi_rdata(m_rdata[1]),
    .s_axi_awvalid(s_awvalid), .s_axi_awready(s_awready), .s_axi_awaddr(s_awaddr),
    .s_axi_awprot(s_awprot), .s_axi_wvalid(s_wvalid), .s_axi_wready(s_wready),
    .s_axi_wdata(s_wdata), .s_axi_wstrb(s_wstrb), .s_axi_bvalid(s_bvalid),
    .s_axi_bready(s_bready), .s_axi_arvalid(s_arvalid), .s_axi_arready(s_arready),
    .s_axi_araddr(s_araddr), .s_axi_arprot(s_arprot), .s_axi_rvalid(s_rvalid),
    .s_axi_rready(s_rready), .s_axi_rdata(s_rdata),
    .grant_id(grant_id), .busy(busy)
  );

  // ---------------- memory slave: mem[i] resets to 0xA5A5_0000 + i ----------------
  logic [31:0] mem [64];
  logic        sl_aw_got, sl_w_got;
  logic [31:0] sl_awaddr, sl_wdata;
  logic [3:0]  sl_wstrb;

  assign s_awready = !sl_aw_got && !s_bvalid;
  assign s_wready  = !sl_w_got && !s_bvalid;
  assign s_arready = !s_rvalid;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'hA5A5_0000 + i;
      sl_aw_got <= 1'b0; sl_w_got <= 1'b0; s_bvalid <= 1'b0; s_rvalid <= 1'b0;
      sl_awaddr <= '0; sl_wdata <= '0; sl_wstrb <= '0; s_rdata <= '0;
    end else begin
      if (s_awvalid && s_awready) begin sl_aw_got <= 1'b1; sl_awaddr <= s_awaddr; end
      if (s_wvalid && s_wready) begin
        sl_w_got <= 1'b1; sl_wdata <= s_wdata; sl_wstrb <= s_wstrb;
      end
      if (sl_aw_got && sl_w_got && !s_bvalid) begin
        for (int b = 0; b < 4; b++)
          if (sl_wstrb[b]) mem[sl_awaddr[7:2]][b*8 +: 8] <= sl_wdata[b*8 +: 8];
        s_bvalid <= 1'b1; sl_aw_got <= 1'b0; sl_w_got <= 1'b0;
      end
      if (s_bvalid && s_bready) s_bvalid <= 1'b0;
      if (s_arvalid && s_arready) begin s_rvalid <= 1'b1; s_rdata <= mem[s_araddr[7:2]]; end
      if (s_rvalid && s_rready) s_rvalid <= 1'b0;
    end
  end

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_fail = 0;
  logic        exp_grant [$];
  logic [31:0] exp_r0 [$];
  logic [31:0] exp_r1 [$];
  int          exp_b_cnt [2];
  int          sar_hi = 0;
  logic        busy_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!resetn) begin
      busy_prev = 1'b0;
    end else begin
      if (s_arvalid) sar_hi++;
      if (busy && !busy_prev) begin
        if (exp_grant.size() == 0) check("unexpected_grant", {31'b0, grant_id}, 32'hFFFF_FFFF);
        else check("grant_order", {31'b0, grant_id}, {31'b0, exp_grant.pop_front()});
      end
      busy_prev = busy;
      for (int n = 0; n < 2; n++) begin
        if (!(busy && grant_id == n[0]))
          check($sformatf("nongrant_zero_m%0d", n),
                m_rdata[n] | {27'b0, m_awready[n], m_wready[n], m_bvalid[n], m_arready[n],
                m_rvalid[n]}, 32'h0);
        if (m_rvalid[n] && m_rready[n]) begin
          if (n == 0 && exp_r0.size() != 0) check("rdata_m0", m_rdata[0], exp_r0.pop_front());
          else if (n == 1 && exp_r1.size() != 0) check("rdata_m1", m_rdata[1], exp_r1.pop_front());
          else check($sformatf("unexpected_rvalid_m%0d", n), 32'h1, 32'h0);
        end
        if (m_bvalid[n] && m_bready[n]) begin
          check($sformatf("bvalid_expected_m%0d", n), {31'b0, exp_b_cnt[n] > 0}, 32'h1);
          if (exp_b_cnt[n] > 0) exp_b_cnt[n]--;
        end
      end
    end
  end

  // ---------------- master drivers ----------------
  task automatic do_read(input int id, input logic [31:0] addr, input logic [31:0] exp);
    int t;
    logic hs;
    if (id == 0) exp_r0.push_back(exp); else exp_r1.push_back(exp);
    m_araddr[id] = addr; m_arvalid[id] = 1'b1; m_rready[id] = 1'b1;
    t = 0; hs = 1'b0;
    while (!hs && t < 100) begin
      @(negedge clk); hs = m_arready[id]; @(posedge clk); #1; t++;
    end
    m_arvalid[id] = 1'b0;
    if (!hs) check($sformatf("timeout_ar_m%0d", id), 32'h0, 32'h1);
    t = 0; hs = 1'b0;
    while (!hs && t < 100) begin
      @(negedge clk); hs = m_rvalid[id]; @(posedge clk); #1; t++;
    end
    m_rready[id] = 1'b0;
    if (!hs) check($sformatf("timeout_r_m%0d", id), 32'h0, 32'h1);
  endtask

  task automatic do_write(input int id, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb);
    int t;
    logic a, w, aw_ok, w_ok, hs;
    exp_b_cnt[id]++;
    m_awaddr[id] = addr; m_wdata[id] = data; m_wstrb[id] = strb;
    m_awvalid[id] = 1'b1; m_wvalid[id] = 1'b1; m_bready[id] = 1'b1;
    t = 0; aw_ok = 1'b0; w_ok = 1'b0;
    while (!(aw_ok && w_ok) && t < 100) begin
      @(negedge clk);
      a = m_awvalid[id] && m_awready[id];
      w = m_wvalid[id] && m_wready[id];
      @(posedge clk); #1; t++;
      if (a) begin m_awvalid[id] = 1'b0; aw_ok = 1'b1; end
      if (w) begin m_wvalid[id] = 1'b0; w_ok = 1'b1; end
    end
    if (!(aw_ok && w_ok)) check($sformatf("timeout_aw_w_m%0d", id), 32'h0, 32'h1);
    m_awvalid[id] = 1'b0; m_wvalid[id] = 1'b0;
    t = 0; hs = 1'b0;
    while (!hs && t < 100) begin
      @(negedge clk); hs = m_bvalid[id]; @(posedge clk); #1; t++;
    end
    m_bready[id] = 1'b0;
    if (!hs) check($sformatf("timeout_b_m%0d", id), 32'h0, 32'h1);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_m_out"}, m_rdata[0] | m_rdata[1] | {22'b0, m_awready[0], m_wready[0],
          m_bvalid[0], m_arready[0], m_rvalid[0], m_awready[1], m_wready[1], m_bvalid[1],
          m_arready[1], m_rvalid[1]}, 32'h0);
    check({name, "_s_ctl"}, {27'b0, s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready}, 32'h0);
    check({name, "_s_data"}, s_awaddr | s_araddr | s_wdata | {25'b0, s_awprot, s_wstrb}, 32'h0);
    check({name, "_status"}, {30'b0, busy, grant_id}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int t;
    logic hs;
    int sar_start;
    for (int n = 0; n < 2; n++) begin
      m_awvalid[n] = 1'b0; m_wvalid[n] = 1'b0; m_bready[n] = 1'b0; m_arvalid[n] = 1'b0;
      m_rready[n] = 1'b0; m_awaddr[n] = '0; m_araddr[n] = '0; m_wdata[n] = '0;
      m_wstrb[n] = '0; m_awprot[n] = '0; m_arprot[n] = '0; exp_b_cnt[n] = 0;
    end
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_all_zero("reset");
    @(negedge clk); resetn = 1'b1;
    @(posedge clk); #1;

    // 1: lone m0 read of 0x10 -> mem[4]
    exp_grant.push_back(1'b0);
    fork
      do_read(0, 32'h0000_0010, 32'hA5A5_0004);
      begin
        @(posedge clk); #1;
        check("t1_busy", {31'b0, busy}, 32'h1);
        check("t1_grant", {31'b0, grant_id}, 32'h0);
        check("t1_s_araddr", s_araddr, 32'h0000_0010);
        check("t1_s_arvalid", {31'b0, s_arvalid}, 32'h1);
      end
    join
    @(posedge clk); #1;

    // 2: m0 write then read back
    exp_grant.push_back(1'b0); exp_grant.push_back(1'b0);
    do_write(0, 32'h0001_0000, 32'hDEAD_BEEF, 4'hF);
    do_read(0, 32'h0001_0000, 32'hDEAD_BEEF);

    // 4: m1 write and read together; the write must land first
    exp_grant.push_back(1'b1); exp_grant.push_back(1'b1);
    fork
      do_write(1, 32'h0001_0004, 32'h1234_5678, 4'hF);
      do_read(1, 32'h0001_0004, 32'h1234_5678);
    join

    // 3: simultaneous reads, 4 rounds; last served is m1, so both policies give m0 then m1
    for (int r = 0; r < 4; r++) begin
      exp_grant.push_back(1'b0); exp_grant.push_back(1'b1);
      fork
        do_read(0, 32'h0000_0010, 32'hA5A5_0004);
        do_read(1, 32'h0000_0018, 32'hA5A5_0006);
      join
    end

    // 5: m0 keeps arvalid high after the AR handshake, rready low for 5 cycles
    exp_grant.push_back(1'b0);
    exp_r0.push_back(32'hA5A5_0004);
    sar_start = sar_hi;
    m_araddr[0] = 32'h0000_0010; m_arvalid[0] = 1'b1; m_rready[0] = 1'b0;
    t = 0; hs = 1'b0;
    while (!hs && t < 100) begin
      @(negedge clk); hs = m_arready[0]; @(posedge clk); #1; t++;
    end
    if (!hs) check("timeout_t5_ar", 32'h0, 32'h1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("t5_busy_grant", {30'b0, busy, grant_id}, 32'h2);
      check("t5_s_arvalid_masked", {31'b0, s_arvalid}, 32'h0);
    end
    @(posedge clk); #1;
    m_arvalid[0] = 1'b0; m_rready[0] = 1'b1;
    t = 0; hs = 1'b0;
    while (!hs && t < 100) begin
      @(negedge clk); hs = m_rvalid[0]; @(posedge clk); #1; t++;
    end
    m_rready[0] = 1'b0;
    if (!hs) check("timeout_t5_r", 32'h0, 32'h1);
    check("t5_single_arvalid", sar_hi - sar_start, 32'h1);

    // tie right after an m0 transaction: policy decides
`ifdef AXI_ARB_ROUND_ROBIN_EN
    exp_grant.push_back(1'b1); exp_grant.push_back(1'b0);
`else
    exp_grant.push_back(1'b0); exp_grant.push_back(1'b1);
`endif
    fork
      do_read(0, 32'h0000_0014, 32'hA5A5_0005);
      do_read(1, 32'h0001_0000, 32'hDEAD_BEEF);
    join

    // 6: reset during a write after aw_done (wvalid held off)
    exp_grant.push_back(1'b0);
    m_awaddr[0] = 32'h0000_0020; m_wdata[0] = 32'hCAFE_F00D; m_wstrb[0] = 4'hF;
    m_awvalid[0] = 1'b1; m_wvalid[0] = 1'b0; m_bready[0] = 1'b1;
    t = 0; hs = 1'b0;
    while (!hs && t < 100) begin
      @(negedge clk); hs = m_awready[0]; @(posedge clk); #1; t++;
    end
    if (!hs) check("timeout_t6_aw", 32'h0, 32'h1);
    m_awvalid[0] = 1'b0;
    @(negedge clk);
    check("t6_busy_before_reset", {31'b0, busy}, 32'h1);
    check("t6_aw_masked", {31'b0, s_awvalid}, 32'h0);
    resetn = 1'b0;
    #1 check_all_zero("t6_reset");
    m_bready[0] = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("t6_idle_in_reset", {31'b0, busy}, 32'h0);
    resetn = 1'b1;
    @(posedge clk); #1;
    exp_grant.push_back(1'b0); exp_grant.push_back(1'b1);
    fork
      do_read(0, 32'h0000_0010, 32'hA5A5_0004);
      do_read(1, 32'h0000_0020, 32'hA5A5_0008);
    join

    repeat (3) @(posedge clk);
    check("end_grant_queue", exp_grant.size(), 32'h0);
    check("end_rdata_queues", exp_r0.size() + exp_r1.size(), 32'h0);
    check("end_bresp_pending", exp_b_cnt[0] + exp_b_cnt[1], 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
